// File: rtl/ram1_pkg.sv
// Shared types and defaults for the single-SRAM two-port arbiter.
package ram1_pkg;

  localparam int unsigned AW_DEFAULT          = 18;
  localparam int unsigned DW_DEFAULT          = 16;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 1;
  // Wide enough for the largest legal WAIT_CYCLES (7).
  localparam int unsigned CNT_W               = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not served last.
module rr_arb2
  import ram1_pkg::*;
(
  input  logic  req_if,
  input  logic  req_mem,
  input  port_e last_grant,
  output logic  gnt_valid_c,
  output port_e gnt_port_c
);

  // Pick the winner from the two level requests and the previous grant.
  always_comb begin
    gnt_valid_c = req_if | req_mem;
    gnt_port_c  = PORT_IF;
    if (req_if && req_mem) begin
      gnt_port_c = (last_grant == PORT_IF) ? PORT_MEM : PORT_IF;
    end else if (req_mem) begin
      gnt_port_c = PORT_MEM;
    end
  end

endmodule

// File: rtl/ram1_arbiter.sv
// Shares one asynchronous SRAM between an instruction-fetch port and a data port.
module ram1_arbiter
  import ram1_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int unsigned AW          = AW_DEFAULT,
  parameter int unsigned DW          = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ack,
  output logic [AW-1:0] Ram1Addr,
  inout  wire  [DW-1:0] Ram1Data,
  output logic          Ram1OE,
  output logic          Ram1WE,
  output logic          Ram1EN
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  port_e            gnt_q, gnt_d;
  port_e            last_grant_q, last_grant_d;
  logic             dir_q, dir_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             if_ack_q, if_ack_d;
  logic             mem_ack_q, mem_ack_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    mem_rdata_q, mem_rdata_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             drive_q, drive_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;

  logic  gnt_valid_c;
  port_e gnt_port_c;

  rr_arb2 u_rr_arb2 (
    .req_if      (if_req),
    .req_mem     (mem_req),
    .last_grant  (last_grant_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_port_c  (gnt_port_c)
  );

  // Next-state, transaction latching and registered pin values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          state_d      = ST_SETUP;
          gnt_d        = gnt_port_c;
          last_grant_d = gnt_port_c;
          wdata_d      = mem_wdata;
          if (gnt_port_c == PORT_MEM) begin
            dir_d  = mem_we;
            addr_d = mem_addr;
          end else begin
            dir_d  = 1'b0;
            addr_d = if_addr;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_LOAD;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          if_ack_d  = (gnt_q == PORT_IF);
          mem_ack_d = (gnt_q == PORT_MEM);
          // Read data is sampled while OE is still low.
          if (!dir_q) begin
            if (gnt_q == PORT_IF) begin
              if_rdata_d = Ram1Data;
            end else begin
              mem_rdata_d = Ram1Data;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes and bus drive follow the state being entered so the pins are flop outputs.
    oe_n_d     = !((state_d == ST_ACCESS) && !dir_d);
    we_n_d     = !((state_d == ST_ACCESS) && dir_d);
    drive_d    = dir_d && (state_d != ST_IDLE);
    ram_addr_d = (state_d != ST_IDLE) ? addr_d : '0;
  end

  // Control state and pin registers; reset forces the SRAM pins safe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gnt_q        <= PORT_IF;
      last_grant_q <= PORT_IF;
      dir_q        <= 1'b0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      drive_q      <= 1'b0;
      ram_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      dir_q        <= dir_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      drive_q      <= drive_d;
      ram_addr_q   <= ram_addr_d;
    end
  end

  // Latched address and write data; only meaningful while a transaction is in flight.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign Ram1Data  = drive_q ? wdata_q : {DW{1'bz}};
  assign Ram1Addr  = ram_addr_q;
  assign Ram1OE    = oe_n_q;
  assign Ram1WE    = we_n_q;
  assign Ram1EN    = ~rst;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter with a behavioural asynchronous SRAM.
module tb_ram1_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [17:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_oe;
  logic        ram_we;
  logic        ram_en;

  // Second instance for the longer access window.
  logic        req3;
  logic [15:0] rdata3;
  logic        ack3;
  logic [15:0] mem_rdata3;
  logic        mem_ack3;
  logic [17:0] addr3;
  wire  [15:0] ram3_data;
  logic        oe3;
  logic        we3;
  logic        en3;

  int n_cmp;
  int n_err;
  logic wr_win;

  logic [15:0] sram [0:262143];

  ram1_arbiter #(.WAIT_CYCLES(1), .AW(18), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Ram1Addr(ram_addr), .Ram1Data(ram_data), .Ram1OE(ram_oe), .Ram1WE(ram_we), .Ram1EN(ram_en)
  );

  ram1_arbiter #(.WAIT_CYCLES(3), .AW(18), .DW(16)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(req3), .if_addr(18'h00055), .if_rdata(rdata3), .if_ack(ack3),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(18'h00000), .mem_wdata(16'h0000),
    .mem_rdata(mem_rdata3), .mem_ack(mem_ack3),
    .Ram1Addr(addr3), .Ram1Data(ram3_data), .Ram1OE(oe3), .Ram1WE(we3), .Ram1EN(en3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives on an enabled read, stores on every clock edge WE is low.
  assign ram_data  = (!ram_en && !ram_oe && ram_we) ? sram[ram_addr] : 16'hzzzz;
  assign ram3_data = (!en3 && !oe3) ? 16'hA5C3 : 16'hzzzz;

  always @(posedge clk) begin
    if (!ram_en && !ram_we) sram[ram_addr] <= ram_data;
  end

  // Continuous bus-safety checks on the main instance.
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (!ram_oe && !ram_we) begin
        n_err++;
        $display("FAIL strobe_overlap: OE=%b WE=%b, must not both be 0", ram_oe, ram_we);
      end
      n_cmp++;
      if (ram_oe && !wr_win && !$isunknown(ram_data) && ram_data != 16'h0000) begin
        n_err++;
        $display("FAIL bus_drive: Ram1Data=%h outside a write, expected released", ram_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_oe, ram_we, ram_en, ram_addr} !== {3'b111, 18'h0}) begin
      n_err++;
      $display("FAIL reset_pins: oe/we/en/addr=%h expected %h", {ram_oe, ram_we, ram_en, ram_addr}, {3'b111, 18'h0});
    end
    n_cmp++;
    if ({if_ack, mem_ack, if_rdata, mem_rdata} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_outs: acks/rdata=%h expected 0", {if_ack, mem_ack, if_rdata, mem_rdata});
    end
    n_cmp++;
    if (!$isunknown(ram_data) && ram_data != 16'h0000) begin
      n_err++;
      $display("FAIL reset_bus: Ram1Data=%h expected released", ram_data);
    end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if ({ram_en, ram_oe, ram_we, ram_addr} !== {3'b011, 18'h0}) begin
      n_err++;
      $display("FAIL post_reset_idle: en/oe/we/addr=%h expected %h", {ram_en, ram_oe, ram_we, ram_addr}, {3'b011, 18'h0});
    end
  endtask

  task automatic test_single_fetch();
    logic [21:0] exp_v;
    if_addr = 18'h00010;
    if_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      exp_v = {(c == 2) ? 1'b0 : 1'b1, 1'b1, (c == 3), 1'b0, (c <= 3) ? 18'h00010 : 18'h0};
      n_cmp++;
      if ({ram_oe, ram_we, if_ack, mem_ack, ram_addr} !== exp_v) begin
        n_err++;
        $display("FAIL fetch_c%0d: oe/we/ifack/memack/addr=%h expected %h", c, {ram_oe, ram_we, if_ack, mem_ack, ram_addr}, exp_v);
      end
      if (c == 3) begin
        n_cmp++;
        if (if_rdata !== 16'hBEEF) begin
          n_err++;
          $display("FAIL fetch_rdata: if_rdata=%h expected beef", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_req_drop();
    sram[18'h00011] = 16'h7E57;
    if_addr = 18'h00011;
    if_req  = 1'b1;
    cyc();
    if_req = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({if_ack, if_rdata} !== {1'b1, 16'h7E57}) begin
      n_err++;
      $display("FAIL drop_ack: ack/rdata=%h expected %h", {if_ack, if_rdata}, {1'b1, 16'h7E57});
    end
    cyc();
    cyc();
    n_cmp++;
    if ({if_ack, ram_addr, if_rdata} !== {1'b0, 18'h0, 16'h7E57}) begin
      n_err++;
      $display("FAIL drop_idle: ack/addr/rdata=%h expected %h", {if_ack, ram_addr, if_rdata}, {1'b0, 18'h0, 16'h7E57});
    end
  endtask

  task automatic test_single_write();
    logic [21:0] exp_v;
    mem_we    = 1'b1;
    mem_addr  = 18'h3FFFF;
    mem_wdata = 16'h1234;
    mem_req   = 1'b1;
    wr_win    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      exp_v = {1'b1, (c == 2) ? 1'b0 : 1'b1, 1'b0, (c == 3), (c <= 3) ? 18'h3FFFF : 18'h0};
      n_cmp++;
      if ({ram_oe, ram_we, if_ack, mem_ack, ram_addr} !== exp_v) begin
        n_err++;
        $display("FAIL write_c%0d: oe/we/ifack/memack/addr=%h expected %h", c, {ram_oe, ram_we, if_ack, mem_ack, ram_addr}, exp_v);
      end
      if (c <= 3) begin
        n_cmp++;
        if (ram_data !== 16'h1234) begin
          n_err++;
          $display("FAIL write_data_c%0d: Ram1Data=%h expected 1234", c, ram_data);
        end
      end
      if (c == 3) mem_req = 1'b0;
      if (c == 4) wr_win = 1'b0;
    end
    n_cmp++;
    if ({sram[18'h3FFFF], mem_rdata} !== {16'h1234, 16'h0000}) begin
      n_err++;
      $display("FAIL write_stored: sram/mem_rdata=%h expected %h", {sram[18'h3FFFF], mem_rdata}, {16'h1234, 16'h0000});
    end
    mem_we  = 1'b0;
    if_addr = 18'h3FFFF;
    if_req  = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if ({if_ack, if_rdata} !== {1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL write_readback: ack/rdata=%h expected %h", {if_ack, if_rdata}, {1'b1, 16'h1234});
    end
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack;
    if_addr  = 18'h00010;
    mem_addr = 18'h3FFFF;
    mem_we   = 1'b0;
    if_req   = 1'b1;
    mem_req  = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      exp_ack = {(c == 7 || c == 15), (c == 3 || c == 11)};
      n_cmp++;
      if ({if_ack, mem_ack} !== exp_ack) begin
        n_err++;
        $display("FAIL rr_ack_c%0d: if_ack/mem_ack=%b expected %b", c, {if_ack, mem_ack}, exp_ack);
      end
      if (c == 1 || c == 5) begin
        n_cmp++;
        if (ram_addr !== ((c == 1) ? 18'h3FFFF : 18'h00010)) begin
          n_err++;
          $display("FAIL rr_grant_c%0d: Ram1Addr=%h expected %h", c, ram_addr, (c == 1) ? 18'h3FFFF : 18'h00010);
        end
      end
      if (c == 15) begin
        n_cmp++;
        if ({mem_rdata, if_rdata} !== {16'h1234, 16'hBEEF}) begin
          n_err++;
          $display("FAIL rr_rdata: mem/if rdata=%h expected %h", {mem_rdata, if_rdata}, {16'h1234, 16'hBEEF});
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
      end
    end
  endtask

  task automatic test_wait3();
    logic [1:0] exp_v;
    req3 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      exp_v = {(c >= 2 && c <= 4) ? 1'b0 : 1'b1, (c == 5)};
      n_cmp++;
      if ({oe3, ack3} !== exp_v) begin
        n_err++;
        $display("FAIL wait3_c%0d: oe/ack=%b expected %b", c, {oe3, ack3}, exp_v);
      end
      if (c == 5) begin
        n_cmp++;
        if (rdata3 !== 16'hA5C3) begin
          n_err++;
          $display("FAIL wait3_rdata: rdata=%h expected a5c3", rdata3);
        end
        req3 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    mem_we    = 1'b1;
    mem_addr  = 18'h00020;
    mem_wdata = 16'h5555;
    mem_req   = 1'b1;
    wr_win    = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if ({ram_we, ram_data} !== {1'b0, 16'h5555}) begin
      n_err++;
      $display("FAIL rstw_access: we/data=%h expected %h", {ram_we, ram_data}, {1'b0, 16'h5555});
    end
    #2;
    rst = 1'b0;
    #1;
    wr_win  = 1'b0;
    mem_req = 1'b0;
    n_cmp++;
    if ({ram_oe, ram_we, ram_en, ram_addr, mem_ack, if_rdata} !== {3'b111, 18'h0, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL rstw_pins: oe/we/en/addr/ack/rdata=%h expected %h", {ram_oe, ram_we, ram_en, ram_addr, mem_ack, if_rdata}, {3'b111, 18'h0, 1'b0, 16'h0});
    end
    n_cmp++;
    if (!$isunknown(ram_data) && ram_data != 16'h0000) begin
      n_err++;
      $display("FAIL rstw_bus: Ram1Data=%h expected released", ram_data);
    end
    cyc();
    n_cmp++;
    if ({mem_ack, sram[18'h00020]} !== {1'b0, 16'h0BAD}) begin
      n_err++;
      $display("FAIL rstw_noack: ack/sram=%h expected %h", {mem_ack, sram[18'h00020]}, {1'b0, 16'h0BAD});
    end
    rst     = 1'b1;
    mem_we  = 1'b0;
    if_addr = 18'h00010;
    if_req  = 1'b1;
    cyc();
    n_cmp++;
    if (ram_addr !== 18'h00010) begin
      n_err++;
      $display("FAIL rstw_regrant: Ram1Addr=%h expected 00010", ram_addr);
    end
    cyc();
    cyc();
    n_cmp++;
    if ({if_ack, mem_ack, if_rdata} !== {2'b10, 16'hBEEF}) begin
      n_err++;
      $display("FAIL rstw_read: acks/rdata=%h expected %h", {if_ack, mem_ack, if_rdata}, {2'b10, 16'hBEEF});
    end
    if_req = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    wr_win    = 1'b0;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = 18'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 18'h0;
    mem_wdata = 16'h0;
    req3      = 1'b0;
    sram[18'h00010] = 16'hBEEF;
    sram[18'h00020] = 16'h0BAD;
    sram[18'h3FFFF] = 16'h0000;
    test_reset();
    test_single_fetch();
    test_req_drop();
    test_single_write();
    test_round_robin();
    test_wait3();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
